// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants and types for the interrupt controller
//
// Purpose: register offsets (decoded from addr[7:0]) and the FSM state type.
// Ports:   none (package).

package irq_ctrl_pkg;

  localparam logic [7:0] PENDING_ADDR = 8'h00;  // R, W1C
  localparam logic [7:0] MASK_ADDR    = 8'h04;  // RW
  localparam logic [7:0] SET_ADDR     = 8'h08;  // W, reads 0
  localparam logic [7:0] STATUS_ADDR  = 8'h0C;  // R, {code, 1'b0, inflight}

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - split 32-bit register bus shared by the tile SFR blocks
//
// Purpose: request/response register bus. ack is the request acceptance,
//          resp/rdata return read data one cycle after the request edge.
// Signals: req, we, addr[31:0], wdata[31:0] (master -> slave)
//          ack, resp, rdata[31:0]          (slave -> master)

interface MemSplit32;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        resp;
  logic [31:0] rdata;

  modport Master (output req, we, addr, wdata, input ack, resp, rdata);
  modport Slave  (input req, we, addr, wdata, output ack, resp, rdata);
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// rtl/irq_ctrl_prio_enc.sv - lowest-index-wins priority encoder
//
// Purpose: combinational encoder; code_bo is the index of the lowest set
//          bit of req_bi, valid_o is high when any bit is set.
// Ports:   req_bi [W-1:0] in, valid_o out, code_bo [CW-1:0] out

module irq_prio_enc #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic [W-1:0]  req_bi,
  output logic          valid_o,
  output logic [CW-1:0] code_bo
);

  // Scan from the top down so the last (lowest) set bit overwrites the rest.
  always_comb begin
    valid_o = |req_bi;
    code_bo = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_bi[i]) code_bo = CW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - per-tile interrupt controller with req/ack CPU handshake
//
// Purpose: latches interrupt requests into PENDING, masks them, and presents
//          the lowest-index eligible line to the CPU. Supported range:
//          IRQ_NUM_POW 1..4 (lines fit in one 32-bit register).
// Config:  define IRQ_CTRL_EDGE_EN for rising-edge detection of irq_bi;
//          default build is level-sensitive.
// Ports:   clk_i, rst_i (sync, active-high)
//          host        MemSplit32.Slave register bus
//          irq_bi      [N-1:0] interrupt lines
//          sgi_req_i / sgi_code_bi  software interrupt pulse and line number
//          irq_req_o / irq_code_bo  request and code to the CPU
//          irq_ack_i   CPU acceptance of the presented code

module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                              IRQ_NUM_POW  = 4,
  parameter logic [(1 << IRQ_NUM_POW) - 1:0] MASK_DEFAULT = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  MemSplit32.Slave                          host,
  input  logic [(1 << IRQ_NUM_POW) - 1:0]   irq_bi,
  input  logic                              sgi_req_i,
  input  logic [IRQ_NUM_POW-1:0]            sgi_code_bi,
  output logic                              irq_req_o,
  output logic [IRQ_NUM_POW-1:0]            irq_code_bo,
  input  logic                              irq_ack_i
);

  localparam int N = 1 << IRQ_NUM_POW;

  state_t                 r_state;
  logic [N-1:0]           r_pending;
  logic [N-1:0]           r_mask;
  logic                   r_req;
  logic [IRQ_NUM_POW-1:0] r_code;
  logic                   r_resp;
  logic [31:0]            r_rdata;

  logic                   w_wr;
  logic                   w_rd;
  logic [7:0]             w_addr;
  logic [N-1:0]           w_wdata;
  logic [N-1:0]           w_irq_in;
  logic [N-1:0]           w_set;
  logic [N-1:0]           w_clr;
  logic [31:0]            w_rdata;
  logic                   w_enc_valid;
  logic [IRQ_NUM_POW-1:0] w_enc_code;
  logic                   w_unused_bits;

  assign host.ack  = host.req;
  assign host.resp = r_resp;
  assign host.rdata = r_rdata;
  assign irq_req_o   = r_req;
  assign irq_code_bo = r_code;

  assign w_wr    = host.req & host.we;
  assign w_rd    = host.req & ~host.we;
  assign w_addr  = host.addr[7:0];
  assign w_wdata = host.wdata[N-1:0];
  assign w_unused_bits = &{1'b0, host.addr[31:8], host.wdata[31:N]};

`ifdef IRQ_CTRL_EDGE_EN
  logic [N-1:0] r_irq_prev;
  assign w_irq_in = irq_bi & ~r_irq_prev;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_irq_prev <= '0;
    else       r_irq_prev <= irq_bi;
  end
`else
  assign w_irq_in = irq_bi;
`endif

  // Sets are OR'ed in after clears so a same-edge set keeps the bit pending.
  always_comb begin
    w_set = w_irq_in;
    if (sgi_req_i) w_set = w_set | (N'(1) << sgi_code_bi);
    if (w_wr && w_addr == SET_ADDR) w_set = w_set | w_wdata;
    w_clr = '0;
    if (w_wr && w_addr == PENDING_ADDR) w_clr = w_wdata;
    if (r_state == REQ && irq_ack_i) w_clr = w_clr | (N'(1) << r_code);
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      PENDING_ADDR: w_rdata = 32'(r_pending);
      MASK_ADDR:    w_rdata = 32'(r_mask);
      STATUS_ADDR:  w_rdata = 32'({r_code, 1'b0, r_req});
      default:      w_rdata = '0;
    endcase
  end

  irq_prio_enc #(.W(N), .CW(IRQ_NUM_POW)) u_prio_enc (
    .req_bi  (r_pending & r_mask),
    .valid_o (w_enc_valid),
    .code_bo (w_enc_code)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_mask    <= MASK_DEFAULT;
      r_req     <= 1'b0;
      r_code    <= '0;
      r_resp    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_wr && w_addr == MASK_ADDR) r_mask <= w_wdata;
      r_resp <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
      case (r_state)
        IDLE: begin
          if (w_enc_valid) begin
            r_code  <= w_enc_code;
            r_req   <= 1'b1;
            r_state <= REQ;
          end
        end
        // Code is frozen here; mask/W1C changes cannot withdraw the request.
        REQ: begin
          if (irq_ack_i) begin
            r_req   <= 1'b0;
            r_state <= HOLDOFF;
          end
        end
        HOLDOFF: r_state <= IDLE;
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard testbench for irq_ctrl

module tb_irq_ctrl;

  localparam int          POW  = 4;
  localparam int          N    = 16;
  localparam logic [15:0] MDEF = 16'h0000;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [N-1:0]     irq_bi;
  logic             sgi_req;
  logic [POW-1:0]   sgi_code;
  logic             irq_req;
  logic [POW-1:0]   irq_code;
  logic             irq_ack;

  always #5 clk = ~clk;

  MemSplit32 bus ();

  irq_ctrl #(.IRQ_NUM_POW(POW), .MASK_DEFAULT(MDEF)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .host        (bus),
    .irq_bi      (irq_bi),
    .sgi_req_i   (sgi_req),
    .sgi_code_bi (sgi_code),
    .irq_req_o   (irq_req),
    .irq_code_bo (irq_code),
    .irq_ack_i   (irq_ack)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 0;
  bit done = 0;
  int dut_cnt6 = 0;

  // Reference model: abstract state of the controller as seen by software.
  logic [15:0] m_pend, m_mask, m_prev;
  bit          m_inreq, m_hold;
  int          m_code;

  logic [31:0] rd_q[$];
  int          iq_code[$];
  int          iq_cyc[$];

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] read_val(input logic [7:0] a);
    case (a)
      8'h00:   return {16'h0, m_pend};
      8'h04:   return {16'h0, m_mask};
      8'h0C:   return 32'(m_code * 4 + (m_inreq ? 1 : 0));
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_step(input logic [15:0] irq, input logic sgi, input logic [3:0] sc,
                                 input logic ack, input logic breq, input logic bwe,
                                 input logic [7:0] a, input logic [31:0] wd, input logic rst);
    logic [15:0] eff, set, clr, elig;
    if (rst) begin
      m_pend = 16'h0; m_mask = MDEF; m_prev = 16'h0;
      m_inreq = 0; m_hold = 0; m_code = 0;
      return;
    end
    if (breq && !bwe) rd_q.push_back(read_val(a));
`ifdef IRQ_CTRL_EDGE_EN
    eff = irq & ~m_prev;
`else
    eff = irq;
`endif
    m_prev = irq;
    set = eff;
    if (sgi) set[sc] = 1'b1;
    if (breq && bwe && a == 8'h08) set = set | wd[15:0];
    clr = 16'h0;
    if (breq && bwe && a == 8'h00) clr = wd[15:0];
    if (m_inreq && ack) clr[m_code] = 1'b1;
    elig = m_pend & m_mask;
    if (m_inreq) begin
      if (ack) begin m_inreq = 0; m_hold = 1; end
    end else if (m_hold) begin
      m_hold = 0;
    end else if (elig != 16'h0) begin
      m_code = lowest(elig);
      m_inreq = 1;
      iq_code.push_back(m_code);
      iq_cyc.push_back(cyc + 1);
    end
    m_pend = (m_pend & ~clr) | set;
    if (breq && bwe && a == 8'h04) m_mask = wd[15:0];
  endfunction

  task automatic cyc_drive(input logic [15:0] irq, input logic sgi, input logic [3:0] sc,
                           input logic ack, input logic breq, input logic bwe,
                           input logic [7:0] a, input logic [31:0] wd, input logic rst);
    @(negedge clk);
    irq_bi = irq; sgi_req = sgi; sgi_code = sc; irq_ack = ack;
    bus.req = breq; bus.we = bwe; bus.addr = {24'($urandom), a}; bus.wdata = wd;
    rst_i = rst;
    #1;
    tests++;
    if (bus.ack !== breq) begin
      fails++;
      $display("FAIL bus_ack: ack=%b required %b", bus.ack, breq);
    end
    @(posedge clk);
    m_step(irq, sgi, sc, ack, breq, bwe, a, wd, rst);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(16'h0, 0, 4'h0, 0, 0, 0, 8'h0, 32'h0, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc_drive(16'h0, 0, 4'h0, 0, 1, 1, a, d, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc_drive(16'h0, 0, 4'h0, 0, 1, 0, a, 32'h0, 0);
  endtask

  task automatic ack_when_req(input logic sgi, input logic [3:0] sc);
    int k = 0;
    while (!m_inreq && k < 20) begin idle(1); k++; end
    tests++;
    if (!m_inreq) begin
      fails++;
      $display("FAIL ack_wait: model request=%0d after 20 cycles, required 1", m_inreq);
    end else begin
      cyc_drive(16'h0, sgi, sc, 1, 0, 0, 8'h0, 32'h0, 0);
    end
  endtask

  // Monitor: compares DUT outputs against what the model queued.
  initial begin
    bit prev_req;
    int cur_code;
    wait (mon_en);
    prev_req = 0;
    cur_code = 0;
    while (!done) begin
      @(negedge clk);
      if (bus.resp === 1'b1) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rd_resp: unexpected resp rdata=%h, required no resp", bus.rdata);
        end else begin
          logic [31:0] exp_d;
          exp_d = rd_q.pop_front();
          if (bus.rdata !== exp_d) begin
            fails++;
            $display("FAIL rd_data: rdata=%h required %h (cyc %0d)", bus.rdata, exp_d, cyc);
          end
        end
      end
      tests++;
      if (irq_req !== m_inreq) begin
        fails++;
        $display("FAIL irq_req_level: irq_req_o=%b required %0d (cyc %0d)", irq_req, m_inreq, cyc);
      end
      if (irq_req === 1'b1 && !prev_req) begin
        tests++;
        if (iq_code.size() == 0) begin
          fails++;
          $display("FAIL irq_present: unexpected code=%0d, required none", irq_code);
        end else begin
          int ec, ecy;
          ec = iq_code.pop_front();
          ecy = iq_cyc.pop_front();
          if (int'(irq_code) != ec || cyc != ecy) begin
            fails++;
            $display("FAIL irq_present: code=%0d cyc=%0d required code=%0d cyc=%0d",
                     irq_code, cyc, ec, ecy);
          end
        end
        cur_code = int'(irq_code);
        if (irq_code == 4'd6) dut_cnt6++;
      end else if (irq_req === 1'b1) begin
        tests++;
        if (int'(irq_code) != cur_code) begin
          fails++;
          $display("FAIL irq_stable: code=%0d required %0d", irq_code, cur_code);
        end
      end
      prev_req = (irq_req === 1'b1);
    end
  end

  initial begin
    logic [7:0] addrs [6];
    logic [15:0] irq;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'hFC};
    rst_i = 1; irq_bi = 0; sgi_req = 0; sgi_code = 0; irq_ack = 0;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0;
    cyc_drive(16'h0, 0, 4'h0, 1, 0, 0, 8'h0, 32'h0, 1);
    cyc_drive(16'h0, 0, 4'h0, 1, 0, 0, 8'h0, 32'h0, 1);
    #1;
    tests += 4;
    if (irq_req !== 1'b0)   begin fails++; $display("FAIL rst_req: %b required 0", irq_req); end
    if (irq_code !== 4'h0)  begin fails++; $display("FAIL rst_code: %h required 0", irq_code); end
    if (bus.resp !== 1'b0)  begin fails++; $display("FAIL rst_resp: %b required 0", bus.resp); end
    if (bus.rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: %h required 0", bus.rdata); end
    mon_en = 1;

    // Single pulse on line 1 with mask 0x3.
    wr(8'h04, 32'h3);
    cyc_drive(16'h0002, 0, 4'h0, 0, 0, 0, 8'h0, 32'h0, 0);
    ack_when_req(0, 4'h0);
    rd(8'h00);
    idle(3);

    // Two SET bits: 4 then 7.
    wr(8'h04, 32'hFFFF);
    wr(8'h08, 32'h0090);
    ack_when_req(0, 4'h0);
    ack_when_req(0, 4'h0);
    idle(3);

    // Masked pending, then unmask.
    wr(8'h04, 32'h0);
    cyc_drive(16'h0008, 0, 4'h0, 0, 0, 0, 8'h0, 32'h0, 0);
    idle(1);
    rd(8'h00);
    wr(8'h04, 32'h8);
    ack_when_req(0, 4'h0);
    idle(3);

    // W1C and MASK=0 while in REQ do not withdraw the request.
    wr(8'h04, 32'h4);
    wr(8'h08, 32'h4);
    idle(2);
    wr(8'h00, 32'h4);
    wr(8'h04, 32'h0);
    idle(3);
    ack_when_req(0, 4'h0);
    idle(3);

    // SGI of code 5 on the ack edge of code 5: stays pending and re-presents.
    wr(8'h04, 32'h20);
    wr(8'h08, 32'h20);
    ack_when_req(1, 4'h5);
    rd(8'h00);
    ack_when_req(0, 4'h0);
    idle(3);

    // Reset while in REQ.
    wr(8'h04, 32'h1);
    wr(8'h08, 32'h1);
    idle(3);
    cyc_drive(16'h0, 0, 4'h0, 1, 0, 0, 8'h0, 32'h0, 1);
    rd(8'h0C);
    rd(8'h04);
    rd(8'h00);
    idle(2);

    // Line 6 held high for 10 cycles, acked whenever presented.
    wr(8'h04, 32'h40);
    dut_cnt6 = 0;
    for (int i = 0; i < 10; i++) cyc_drive(16'h0040, 0, 4'h0, m_inreq, 0, 0, 8'h0, 32'h0, 0);
    for (int i = 0; i < 10; i++) cyc_drive(16'h0000, 0, 4'h0, m_inreq, 0, 0, 8'h0, 32'h0, 0);
`ifdef IRQ_CTRL_EDGE_EN
    tests++;
    if (dut_cnt6 != 1) begin
      fails++;
      $display("FAIL edge_once: %0d interrupts on line 6, required 1", dut_cnt6);
    end
`endif
    wr(8'h00, 32'hFFFF);
    idle(4);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      irq = ($urandom % 4 == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
      cyc_drive(irq, ($urandom % 8) == 0, 4'($urandom),
                m_inreq ? (($urandom % 3) == 0) : (($urandom % 8) == 0),
                1'($urandom), 1'($urandom), addrs[$urandom % 6], $urandom,
                ($urandom % 400) == 0);
    end
    idle(4);
    done = 1;
    @(negedge clk);
    tests++;
    if (rd_q.size() != 0) begin
      fails++;
      $display("FAIL rd_drain: %0d reads without resp, required 0", rd_q.size());
    end
    tests++;
    if (iq_code.size() != 0) begin
      fails++;
      $display("FAIL irq_drain: %0d requests not presented, required 0", iq_code.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
